// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller: RAW detection against EX/WB with optional
// forwarding, plus a counter-driven flush/stall state machine feeding fetch/PC.
module hazard_ctrl #(
  parameter int REG_W            = 5,
  parameter int FLUSH_CYCLES     = 2,
  parameter int RAW_STALL_CYCLES = 2,
  parameter int FWD_EN           = 0,
  parameter int ZERO_REG         = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_rd_a,
  input  logic             id_rd_b,
  input  logic [3:0]       id_kind,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_wr_en,
  input  logic             ex_branch_taken,
  input  logic             irq,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             fetch_hold,
  output logic             imem_addr_sel,
  output logic             id_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy,
  output logic [2:0]       flush_cause
);

  localparam int MAX_CYC = (FLUSH_CYCLES > RAW_STALL_CYCLES) ? FLUSH_CYCLES : RAW_STALL_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH_CYCLES);
  localparam logic [CW-1:0] STALL_LD = CW'(RAW_STALL_CYCLES - 1);
  localparam logic          FWD      = (FWD_EN != 0);
  localparam logic          ZREG     = (ZERO_REG != 0);

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;
  typedef enum logic [2:0] {
    C_NONE = 3'd0, C_RESET = 3'd1, C_IRQ = 3'd2,
    C_BRANCH = 3'd3, C_CALL = 3'd4, C_RETURN = 3'd5
  } cause_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  cause_t          cause_q, cause_n;

  logic zero_a, zero_b;
  logic ex_a, ex_b, wb_a, wb_b;
  logic hz_ex, hz_wb;
  logic is_call, is_ret;
  logic event_hi, stall;

  assign zero_a = ZREG && (id_src_a == '0);
  assign zero_b = ZREG && (id_src_b == '0);
  assign ex_a   = (id_src_a == ex_dst) && id_rd_a && ex_wr_en && !zero_a;
  assign ex_b   = (id_src_b == ex_dst) && id_rd_b && ex_wr_en && !zero_b;
  assign wb_a   = (id_src_a == wb_dst) && id_rd_a && wb_wr_en && !zero_a;
  assign wb_b   = (id_src_b == wb_dst) && id_rd_b && wb_wr_en && !zero_b;
  assign hz_ex  = (ex_a || ex_b) && (!FWD || ex_is_load);
  assign hz_wb  = (wb_a || wb_b) && !FWD;

  assign is_call = (id_kind == 4'd6);
  assign is_ret  = (id_kind >= 4'd7) && (id_kind <= 4'd9);

  always_ff @(posedge clk) begin
    state   <= state_n;
    cnt     <= cnt_n;
    cause_q <= cause_n;
  end

  // reset is just the top-priority flush event, so it is folded in here
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cause_n = cause_q;
    if (reset) begin
      state_n = FLUSH; cnt_n = FLUSH_LD; cause_n = C_RESET;
    end else if (irq) begin
      state_n = FLUSH; cnt_n = FLUSH_LD; cause_n = C_IRQ;
    end else if (ex_branch_taken) begin
      state_n = FLUSH; cnt_n = FLUSH_LD; cause_n = C_BRANCH;
    end else if (state == IDLE) begin
      if (is_call) begin
        state_n = FLUSH; cnt_n = FLUSH_LD; cause_n = C_CALL;
      end else if (is_ret) begin
        state_n = FLUSH; cnt_n = FLUSH_LD; cause_n = C_RETURN;
      end else if (hz_ex && (RAW_STALL_CYCLES > 1)) begin
        state_n = STALL; cnt_n = STALL_LD;
      end
    end else if (cnt <= CW'(1)) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      cnt_n = cnt - CW'(1);
    end
  end

  always_comb begin
    event_hi      = reset || irq || ex_branch_taken || ((state == IDLE) && (is_call || is_ret));
    stall         = !event_hi && ((state == STALL) || ((state == IDLE) && (hz_ex || hz_wb)));
    fetch_hold    = stall && !reset && !ex_branch_taken;
    imem_addr_sel = fetch_hold;
    pc_reset      = reset;
    pc_load       = ex_branch_taken && !reset;
    pc_inc        = !reset && !pc_load && !fetch_hold;
    id_bubble     = event_hi || stall || (state != IDLE);
    busy          = (state != IDLE);
    flush_cause   = (state == FLUSH) ? cause_q : C_NONE;
    fwd_a         = 2'd0;
    fwd_b         = 2'd0;
    if (FWD && (state == IDLE) && !reset) begin
      if (ex_a && !ex_is_load) fwd_a = 2'd1;
      else if (wb_a)           fwd_a = 2'd2;
      if (ex_b && !ex_is_load) fwd_b = 2'd1;
      else if (wb_b)           fwd_b = 2'd2;
    end
  end

endmodule
